// File: rtl/stream_mux_pkg.sv
// Shared constants for the stream mux family: arbitration mode codes and the
// select-width helper used to size channel indices.
package stream_mux_pkg;

    localparam int MODE_SEL = 0;
    localparam int MODE_RR  = 1;

    function automatic int sel_width(input int channels);
        return (channels > 1) ? $clog2(channels) : 1;
    endfunction

endpackage

// File: rtl/stream_mux_rr_pick.sv
// Round-robin pick: first requesting channel at or after ptr_i, wrapping
// modulo CHANNELS.
module rr_pick #(
    parameter int CHANNELS = 4,
    parameter int SEL_W    = 2
) (
    input  logic [CHANNELS-1:0] req_i,
    input  logic [SEL_W-1:0]    ptr_i,
    output logic [SEL_W-1:0]    grant_o,
    output logic                grant_vld_o
);

    int pos;

    // NOTE: every output gets a default before the loop, so no path leaves it unassigned (no latch).
    always_comb begin
        grant_o     = '0;
        grant_vld_o = 1'b0;
        pos         = 0;
        // Scan from the farthest offset down so the closest requester wins last.
        for (int k = CHANNELS - 1; k >= 0; k--) begin
            pos = int'(ptr_i) + k;
            if (pos >= CHANNELS) pos = pos - CHANNELS;
            if (req_i[pos]) begin
                grant_o     = SEL_W'(pos);
                grant_vld_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/stream_mux.sv
// N:1 valid/ready stream multiplexer with a single registered output stage;
// the channel is chosen by SEL (MODE_SEL) or by round-robin (MODE_RR).
module stream_mux
    import stream_mux_pkg::*;
#(
    parameter  int WIDTH    = 4,
    parameter  int CHANNELS = 4,
    parameter  int MODE     = MODE_SEL,
    localparam int SEL_W    = sel_width(CHANNELS)
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [CHANNELS*WIDTH-1:0] IN_DATA,
    input  logic [CHANNELS-1:0]       IN_VALID,
    output logic [CHANNELS-1:0]       IN_READY,
    input  logic [SEL_W-1:0]          SEL,
    output logic [WIDTH-1:0]          OUT_DATA,
    output logic [SEL_W-1:0]          OUT_CH,
    output logic                      OUT_VALID,
    input  logic                      OUT_READY
);

    logic [WIDTH-1:0]    out_data_q;
    logic [SEL_W-1:0]    out_ch_q;
    logic                out_valid_q;
    logic [SEL_W-1:0]    ptr_q;
    logic [SEL_W-1:0]    ptr_d;

    logic                load;
    logic                xfer;
    logic [SEL_W-1:0]    grant_idx;
    logic                grant_vld;
    logic [CHANNELS-1:0] grant_oh;
    logic [WIDTH-1:0]    sel_data;

    generate
        if (MODE == MODE_RR) begin : g_rr
            rr_pick #(
                .CHANNELS (CHANNELS),
                .SEL_W    (SEL_W)
            ) u_rr_pick (
                .req_i       (IN_VALID),
                .ptr_i       (ptr_q),
                .grant_o     (grant_idx),
                .grant_vld_o (grant_vld)
            );
        end else begin : g_sel
            // Out-of-range SEL values match no channel and therefore grant nothing.
            always_comb begin
                grant_idx = SEL;
                grant_vld = 1'b0;
                for (int i = 0; i < CHANNELS; i++) begin
                    if (SEL == SEL_W'(i)) grant_vld = IN_VALID[i];
                end
            end
        end
    endgenerate

    assign load = !out_valid_q || OUT_READY;
    assign xfer = grant_vld && load;

    // One-hot grant drives an AND-OR data select.
    always_comb begin
        grant_oh = '0;
        sel_data = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            grant_oh[i] = grant_vld && (grant_idx == SEL_W'(i));
            sel_data    = sel_data | (IN_DATA[i*WIDTH +: WIDTH] & {WIDTH{grant_oh[i]}});
        end
    end

    assign IN_READY = grant_oh & {CHANNELS{load && !RST}};

    always_comb begin
        ptr_d = ptr_q;
        if (MODE == MODE_RR && xfer) begin
            ptr_d = (grant_idx == SEL_W'(CHANNELS - 1)) ? '0 : grant_idx + SEL_W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            out_data_q  <= '0;
            out_ch_q    <= '0;
            out_valid_q <= 1'b0;
            ptr_q       <= '0;
        end else begin
            ptr_q <= ptr_d;
            if (load) begin
                out_valid_q <= grant_vld;
                if (grant_vld) begin
                    out_data_q <= sel_data;
                    out_ch_q   <= grant_idx;
                end
            end
        end
    end

    assign OUT_DATA  = out_data_q;
    assign OUT_CH    = out_ch_q;
    assign OUT_VALID = out_valid_q;

endmodule

// File: tb/tb_stream_mux.sv
// Directed bench: one select-mode and one round-robin instance share inputs;
// each step compares outputs against hand-computed values.
module tb_stream_mux;

    localparam int WIDTH    = 4;
    localparam int CHANNELS = 4;
    localparam int SEL_W    = 2;

    logic                      clk;
    logic                      rst;
    logic [CHANNELS*WIDTH-1:0] in_data;
    logic [CHANNELS-1:0]       in_valid;
    logic [SEL_W-1:0]          sel;
    logic                      out_ready;

    logic [CHANNELS-1:0] s_in_ready,  r_in_ready;
    logic [WIDTH-1:0]    s_out_data,  r_out_data;
    logic [SEL_W-1:0]    s_out_ch,    r_out_ch;
    logic                s_out_valid, r_out_valid;

    int total = 0;
    int bad   = 0;

    stream_mux #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .MODE(0)) u_sel (
        .CLK       (clk),
        .RST       (rst),
        .IN_DATA   (in_data),
        .IN_VALID  (in_valid),
        .IN_READY  (s_in_ready),
        .SEL       (sel),
        .OUT_DATA  (s_out_data),
        .OUT_CH    (s_out_ch),
        .OUT_VALID (s_out_valid),
        .OUT_READY (out_ready)
    );

    stream_mux #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .MODE(1)) u_rr (
        .CLK       (clk),
        .RST       (rst),
        .IN_DATA   (in_data),
        .IN_VALID  (in_valid),
        .IN_READY  (r_in_ready),
        .SEL       (sel),
        .OUT_DATA  (r_out_data),
        .OUT_CH    (r_out_ch),
        .OUT_VALID (r_out_valid),
        .OUT_READY (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst       = 1'b1;
        in_data   = '0;
        in_valid  = 4'b1111;
        sel       = '0;
        out_ready = 1'b1;
        #1;
        check("rst_s_valid", 32'(s_out_valid), 32'd0);
        check("rst_s_data",  32'(s_out_data),  32'd0);
        check("rst_s_ch",    32'(s_out_ch),    32'd0);
        check("rst_s_ready", 32'(s_in_ready),  32'd0);
        check("rst_r_ready", 32'(r_in_ready),  32'd0);
        check("rst_r_valid", 32'(r_out_valid), 32'd0);

        @(negedge clk);
        rst = 1'b0;

        // Select mode, single valid channel
        sel      = 2'd2;
        in_valid = 4'b0100;
        in_data  = 16'h0A00;
        #1;
        check("sel2_ready", 32'(s_in_ready), 32'b0100);
        tick();
        check("sel2_valid", 32'(s_out_valid), 32'd1);
        check("sel2_data",  32'(s_out_data),  32'hA);
        check("sel2_ch",    32'(s_out_ch),    32'd2);

        // Selected channel not valid: no grant, output empties
        sel      = 2'd1;
        in_valid = 4'b1101;
        #1;
        check("sel1_noready", 32'(s_in_ready), 32'd0);
        tick();
        check("sel1_drop_valid", 32'(s_out_valid), 32'd0);
        check("sel1_hold_data",  32'(s_out_data),  32'hA);
        check("sel1_hold_ch",    32'(s_out_ch),    32'd2);

        // Backpressure: load 5 then stall three cycles with changing inputs
        sel      = 2'd0;
        in_valid = 4'b0001;
        in_data  = 16'h0005;
        tick();
        check("bp_load_data", 32'(s_out_data), 32'h5);
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            sel      = SEL_W'(3 - k);
            in_valid = 4'b1111;
            in_data  = 16'h9876 + 16'(k);
            #1;
            check("bp_stall_ready", 32'(s_in_ready), 32'd0);
            tick();
            check("bp_stall_valid", 32'(s_out_valid), 32'd1);
            check("bp_stall_data",  32'(s_out_data),  32'h5);
            check("bp_stall_ch",    32'(s_out_ch),    32'd0);
        end
        out_ready = 1'b1;
        sel       = 2'd3;
        in_valid  = 4'b1000;
        in_data   = 16'h9000;
        #1;
        check("bp_release_ready", 32'(s_in_ready), 32'b1000);
        tick();
        check("bp_next_valid", 32'(s_out_valid), 32'd1);
        check("bp_next_data",  32'(s_out_data),  32'h9);
        check("bp_next_ch",    32'(s_out_ch),    32'd3);

        // Asynchronous reset while a beat is held
        out_ready = 1'b0;
        in_valid  = 4'b1111;
        #2;
        rst = 1'b1;
        #1;
        check("arst_s_valid", 32'(s_out_valid), 32'd0);
        check("arst_s_data",  32'(s_out_data),  32'd0);
        check("arst_s_ch",    32'(s_out_ch),    32'd0);
        check("arst_r_valid", 32'(r_out_valid), 32'd0);
        check("arst_ready",   32'(s_in_ready),  32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Round-robin, all channels valid: first grant from channel 0
        out_ready = 1'b1;
        in_valid  = 4'b1111;
        in_data   = 16'h3210;
        #1;
        check("rr_first_ready", 32'(r_in_ready), 32'b0001);
        for (int k = 0; k < 8; k++) begin
            tick();
            check("rr_seq_valid", 32'(r_out_valid), 32'd1);
            check("rr_seq_ch",    32'(r_out_ch),    32'(k % 4));
            check("rr_seq_data",  32'(r_out_data),  32'(k % 4));
        end

        // Sparse: move PTR to 1, then 4'b1001 grants 3 then 0
        in_valid = 4'b0001;
        in_data  = 16'h000E;
        tick();
        check("rr_ptr1_ch", 32'(r_out_ch), 32'd0);
        in_valid = 4'b1001;
        in_data  = 16'hC00B;
        #1;
        check("rr_sparse_ready3", 32'(r_in_ready), 32'b1000);
        tick();
        check("rr_sparse_ch3",   32'(r_out_ch),   32'd3);
        check("rr_sparse_data3", 32'(r_out_data), 32'hC);
        #1;
        check("rr_sparse_ready0", 32'(r_in_ready), 32'b0001);
        tick();
        check("rr_sparse_ch0",   32'(r_out_ch),   32'd0);
        check("rr_sparse_data0", 32'(r_out_data), 32'hB);

        // Round-robin stall keeps the beat and PTR (next grant is channel 1)
        out_ready = 1'b0;
        in_valid  = 4'b1111;
        in_data   = 16'h7654;
        #1;
        check("rr_stall_ready", 32'(r_in_ready), 32'd0);
        tick();
        check("rr_stall_valid", 32'(r_out_valid), 32'd1);
        check("rr_stall_data",  32'(r_out_data),  32'hB);
        out_ready = 1'b1;
        #1;
        check("rr_ptr_hold_ready", 32'(r_in_ready), 32'b0010);
        tick();
        check("rr_after_stall_ch",   32'(r_out_ch),   32'd1);
        check("rr_after_stall_data", 32'(r_out_data), 32'h5);
        in_valid = 4'b0000;
        tick();
        check("rr_empty_valid", 32'(r_out_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/stream_mux.md
STREAM_MUX -- requirements
Module: stream_mux

Interface
REQ-001 Parameter WIDTH, default 4, data bits per channel (>=1).
REQ-002 Parameter CHANNELS, default 4, number of input channels (2..16).
REQ-003 Parameter MODE, default 0: 0 = explicit select via SEL, 1 = round-robin.
REQ-004 Derived constant SEL_W = max(1, ceil(log2(CHANNELS))).
REQ-005 Port CLK, input, 1, sole clock; all state on rising edge.
REQ-006 Port RST, input, 1, asynchronous active-high reset.
REQ-007 Port IN_DATA, input, CHANNELS*WIDTH, channel i at bits [i*WIDTH +: WIDTH].
REQ-008 Port IN_VALID, input, CHANNELS, per-channel data valid.
REQ-009 Port IN_READY, output, CHANNELS, per-channel accept; at most one bit high.
REQ-010 Port SEL, input, SEL_W, selected channel in MODE 0; ignored in MODE 1.
REQ-011 Port OUT_DATA, output, WIDTH, registered selected data.
REQ-012 Port OUT_CH, output, SEL_W, index of the channel that produced OUT_DATA.
REQ-013 Port OUT_VALID, output, 1, output register holds a beat.
REQ-014 Port OUT_READY, input, 1, downstream accept.

Function
REQ-015 Transfer on a channel occurs when IN_VALID[i] and IN_READY[i] are both high at a rising CLK edge; output transfer when OUT_VALID and OUT_READY are both high.
REQ-016 Output stage is a single register; LOAD = (!OUT_VALID || OUT_READY).
REQ-017 IN_READY[g] = LOAD for the granted channel g only; all other bits 0; IN_READY is combinational from state, SEL and IN_VALID, never from IN_DATA.
REQ-018 MODE 0: g = SEL if SEL < CHANNELS and IN_VALID[SEL]; else no grant and IN_READY = 0.
REQ-019 MODE 1: g = first i with IN_VALID[i] high, scanning PTR, PTR+1, ... wrapping modulo CHANNELS; no grant if IN_VALID = 0.
REQ-020 MODE 1: PTR updates to (g+1) mod CHANNELS only on an input transfer; otherwise holds.
REQ-021 On input transfer, OUT_DATA <= channel g data, OUT_CH <= g, OUT_VALID <= 1 on the same edge; latency input-to-output is 1 cycle.
REQ-022 When LOAD is high and no grant exists, OUT_VALID <= 0; OUT_DATA and OUT_CH hold.
REQ-023 When OUT_VALID and !OUT_READY, OUT_DATA, OUT_CH, OUT_VALID and PTR hold; no input accepted.
REQ-024 Simultaneous output and input transfer in one cycle sustains one beat per cycle with no bubble.
REQ-025 A changing SEL while OUT_VALID && !OUT_READY has no effect on the held beat.
REQ-026 No beat is duplicated or dropped; each input transfer produces exactly one output transfer.

Reset
REQ-027 RST high asynchronously forces OUT_VALID = 0, OUT_DATA = 0, OUT_CH = 0, PTR = 0.
REQ-028 While RST is high IN_READY = 0.
REQ-029 Reset mid-operation discards any held beat; first grant after release in MODE 1 scans from channel 0.

Structure
REQ-030 Mode constants (MODE_SEL = 0, MODE_RR = 1) live in a shared include file used by all mux-family blocks.
REQ-031 Round-robin search is one sub-module rr_pick (inputs request vector and PTR; outputs grant index and grant-valid), instantiated only when MODE = 1.
REQ-032 Wide data selection is built from the existing 2:1 mux primitives or equivalent AND-OR structure; no latches.

Verification
REQ-033 MODE 0, CHANNELS 4, WIDTH 4: SEL=2, IN_VALID=4'b0100, ch2 data 4'hA, OUT_READY=1 -> next cycle OUT_VALID=1, OUT_DATA=4'hA, OUT_CH=2.
REQ-034 MODE 0: SEL=1, IN_VALID=4'b1101 -> IN_READY=0, OUT_VALID falls to 0 after one cycle.
REQ-035 MODE 1: all IN_VALID high, OUT_READY=1 for 8 cycles -> OUT_CH sequence 0,1,2,3,0,1,2,3 with OUT_VALID continuously high.
REQ-036 Backpressure: OUT_VALID=1, OUT_DATA=4'h5, OUT_READY=0 for 3 cycles while inputs change -> OUT_DATA stays 4'h5, IN_READY=0; OUT_READY=1 -> next beat loads same cycle.
REQ-037 MODE 1 sparse: IN_VALID=4'b1001, PTR=1 -> grant 3, then PTR=0 -> grant 0.
REQ-038 Assert RST mid-stream with OUT_VALID=1 -> OUT_VALID=0 immediately (no clock edge), OUT_DATA=0; after release first MODE 1 grant starts at channel 0.
